// File: rtl/rv32i_types.sv
// Shared mp3 types used by the memory-side cache arbiter.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } cache_arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between I-cache and D-cache.
// The winner's address/data/direction are latched for the whole transaction and the
// response is steered back to the granted requester only.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    cache_arb_state_t  state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;

    logic              d_pending;
    logic              pick_d;

    // State and transaction latches; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    // Next-state: grant only from IDLE, return to IDLE on the adaptor response.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;

        d_pending = d_read | d_write;
        // D wins when alone, or on a tie when I was granted last.
        pick_d    = d_pending & (~i_read | (last_grant_q == GNT_I));

        unique case (state_q)
            IDLE: begin
                if (i_read | d_pending) begin
                    if (pick_d) begin
                        state_d      = SERVE_D;
                        last_grant_d = GNT_D;
                        addr_d       = d_address;
                        wdata_d      = d_wdata;
                        // read+write together is illegal; treated as a write.
                        write_d      = d_write;
                    end else begin
                        state_d      = SERVE_I;
                        last_grant_d = GNT_I;
                        addr_d       = i_address;
                        write_d      = 1'b0;
                    end
                end
            end
            SERVE_I: begin
                if (mem_resp) state_d = IDLE;
            end
            SERVE_D: begin
                if (mem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory side from latches only, response side gated by state and mem_resp.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        i_rdata     = '0;
        d_rdata     = '0;

        unique case (state_q)
            SERVE_I: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = mem_rdata;
                end
            end
            SERVE_D: begin
                mem_read  = ~write_q;
                mem_write = write_q;
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with a fixed-latency adaptor model.
module tb_cache_arbiter;
    import rv32i_types::*;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int          LAT = 4;

    localparam logic [LW-1:0] LINE_A5 = {32{8'hA5}};
    localparam logic [LW-1:0] LINE_WB = {8{32'h12345678}};
    localparam logic [LW-1:0] LINE_C3 = {32{8'hC3}};
    localparam logic [LW-1:0] LINE_FF = {LW{1'b1}};

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    int checks;
    int failures;
    bit adapt_en;
    bit mon_en;
    logic [LW-1:0] resp_line;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adaptor model: pulses mem_resp LAT cycles after a request becomes visible.
    initial begin
        int cnt;
        cnt = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (adapt_en) begin
                mem_resp = 1'b0;
                mem_rdata = '0;
                if (rst === 1'b1) cnt = 0;
                else if (mem_read === 1'b1 || mem_write === 1'b1) begin
                    cnt++;
                    if (cnt == LAT) begin
                        mem_resp = 1'b1;
                        mem_rdata = resp_line;
                        cnt = 0;
                    end
                end else cnt = 0;
            end
        end
    end

    // Every-cycle invariants on the response side.
    initial begin
        forever begin
            @(negedge clk);
            assert (!(d_read && d_write)) else $error("illegal d_read with d_write");
            if (mon_en && rst === 1'b0) begin
                checks++;
                if ((i_resp && d_resp) || (!i_resp && i_rdata !== '0) ||
                    (!d_resp && d_rdata !== '0) ||
                    (d_resp !== 1'b0 && dut.state_q == SERVE_I)) begin
                    failures++;
                    $display("FAIL monitor: i_resp=%b d_resp=%b i_rdata_nz=%b d_rdata_nz=%b required exclusive responses, zero idle rdata",
                             i_resp, d_resp, i_rdata != '0, d_rdata != '0);
                end
            end
        end
    end

    task automatic wait_resp(input bit is_d, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((is_d ? d_resp : i_resp) === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic drop_req(input bit is_d);
        @(posedge clk); #1;
        if (is_d) begin
            d_read = 1'b0;
            d_write = 1'b0;
        end else i_read = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0000", {mem_read, mem_write, i_resp, d_resp});
        end
        checks++;
        if (mem_address !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_latch: addr=%h wdata_nz=%b required 0", mem_address, mem_wdata != '0);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d required IDLE", dut.state_q);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_lone_i();
        int cyc;
        resp_line = LINE_A5;
        i_address = 32'h0000_0060;
        i_read = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL lone_i_latency: mem_read=%b required 0 before grant edge", mem_read);
        end
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h60) begin
            failures++;
            $display("FAIL lone_i_req: rd=%b wr=%b addr=%h required 1 0 00000060", mem_read, mem_write, mem_address);
        end
        wait_resp(1'b0, cyc);
        checks++;
        if (cyc !== LAT - 1) begin
            failures++;
            $display("FAIL lone_i_cycles: got %0d required %0d", cyc, LAT - 1);
        end
        checks++;
        if (i_rdata !== LINE_A5 || d_resp !== 1'b0) begin
            failures++;
            $display("FAIL lone_i_data: i_rdata=%h d_resp=%b required a5.. 0", i_rdata, d_resp);
        end
        drop_req(1'b0);
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || mem_read !== 1'b0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL lone_i_pulse: i_resp=%b mem_read=%b state=%0d required 0 0 IDLE", i_resp, mem_read, dut.state_q);
        end
    endtask

    task automatic test_lone_d_write();
        int cyc;
        resp_line = LINE_C3;
        d_address = 32'h0000_0080;
        d_wdata = LINE_WB;
        @(posedge clk); #1;
        d_write = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h80 || mem_wdata !== LINE_WB) begin
            failures++;
            $display("FAIL lone_d_req: wr=%b rd=%b addr=%h wdata=%h required 1 0 00000080 1234..",
                     mem_write, mem_read, mem_address, mem_wdata);
        end
        wait_resp(1'b1, cyc);
        checks++;
        if (cyc !== LAT - 1 || d_rdata !== LINE_C3 || i_resp !== 1'b0) begin
            failures++;
            $display("FAIL lone_d_resp: cycles=%0d d_rdata=%h i_resp=%b required %0d c3.. 0", cyc, d_rdata, i_resp, LAT - 1);
        end
        drop_req(1'b1);
        @(negedge clk);
        checks++;
        if (d_resp !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL lone_d_pulse: d_resp=%b mem_write=%b required 0 0", d_resp, mem_write);
        end
    endtask

    // Both requesting together; expects first_d selects which side must win.
    task automatic run_tie(input string tag, input bit first_d);
        int cyc;
        logic [AW-1:0] first_addr, second_addr;
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0200;
        first_addr  = first_d ? 32'h200 : 32'h100;
        second_addr = first_d ? 32'h100 : 32'h200;
        resp_line = LINE_A5;
        @(posedge clk); #1;
        i_read = 1'b1;
        d_read = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_address !== first_addr || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL %s_first: addr=%h rd=%b required %h 1", tag, mem_address, mem_read, first_addr);
        end
        wait_resp(first_d, cyc);
        checks++;
        if (cyc !== LAT - 1) begin
            failures++;
            $display("FAIL %s_first_cycles: got %0d required %0d", tag, cyc, LAT - 1);
        end
        drop_req(first_d);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL %s_gap: rd=%b state=%0d required 0 IDLE", tag, mem_read, dut.state_q);
        end
        @(negedge clk);
        checks++;
        if (mem_address !== second_addr || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL %s_second: addr=%h rd=%b required %h 1", tag, mem_address, mem_read, second_addr);
        end
        wait_resp(!first_d, cyc);
        checks++;
        if (cyc !== LAT - 1) begin
            failures++;
            $display("FAIL %s_second_cycles: got %0d required %0d", tag, cyc, LAT - 1);
        end
        drop_req(!first_d);
    endtask

    task automatic test_tie_after_reset();
        pulse_reset();
        run_tie("tie_reset", 1'b1);
    endtask

    task automatic test_mid_service();
        int cyc;
        resp_line = LINE_C3;
        i_address = 32'h0000_0300;
        d_address = 32'h0000_0400;
        @(posedge clk); #1;
        i_read = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        d_read = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_address !== 32'h300 || d_resp !== 1'b0) begin
            failures++;
            $display("FAIL mid_hold: addr=%h d_resp=%b required 00000300 0", mem_address, d_resp);
        end
        wait_resp(1'b0, cyc);
        checks++;
        if (cyc !== LAT - 2 || mem_address !== 32'h300 || i_rdata !== LINE_C3) begin
            failures++;
            $display("FAIL mid_i_resp: cycles=%0d addr=%h i_rdata=%h required %0d 00000300 c3..",
                     cyc, mem_address, i_rdata, LAT - 2);
        end
        drop_req(1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_address !== 32'h400 || mem_read !== 1'b1 || dut.state_q !== SERVE_D) begin
            failures++;
            $display("FAIL mid_d_grant: addr=%h rd=%b state=%0d required 00000400 1 SERVE_D",
                     mem_address, mem_read, dut.state_q);
        end
        wait_resp(1'b1, cyc);
        checks++;
        if (cyc !== LAT - 1 || d_rdata !== LINE_C3) begin
            failures++;
            $display("FAIL mid_d_resp: cycles=%0d d_rdata=%h required %0d c3..", cyc, d_rdata, LAT - 1);
        end
        drop_req(1'b1);
    endtask

    // Last grant went to D, so a fresh tie must now favour I.
    task automatic test_repeat_tie();
        run_tie("tie_repeat", 1'b0);
    endtask

    task automatic test_spurious_resp();
        adapt_en = 1'b0;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        mem_rdata = LINE_FF;
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL spurious_resp: i_resp=%b d_resp=%b required 0 0 with zero rdata", i_resp, d_resp);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        checks++;
        if (dut.state_q !== IDLE || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL spurious_state: state=%0d rd=%b wr=%b required IDLE 0 0", dut.state_q, mem_read, mem_write);
        end
        adapt_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        resp_line = LINE_A5;
        d_address = 32'h0000_0500;
        d_wdata = LINE_WB;
        @(posedge clk); #1;
        d_write = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || dut.state_q !== SERVE_D) begin
            failures++;
            $display("FAIL rstmid_start: wr=%b state=%0d required 1 SERVE_D", mem_write, dut.state_q);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        d_write = 1'b0;
        d_read = 1'b1;
        i_read = 1'b1;
        i_address = 32'h0000_0700;
        d_address = 32'h0000_0600;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || mem_address !== '0 ||
            mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL rstmid_outputs: ctrl=%b addr=%h wdata_nz=%b state=%0d required 0000 0 0 IDLE",
                     {mem_read, mem_write, i_resp, d_resp}, mem_address, mem_wdata != '0, dut.state_q);
        end
        @(negedge clk);
        checks++;
        if (mem_address !== 32'h600 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_regrant: addr=%h rd=%b required 00000600 1", mem_address, mem_read);
        end
        wait_resp(1'b1, cyc);
        checks++;
        if (cyc !== LAT - 1) begin
            failures++;
            $display("FAIL rstmid_d_cycles: got %0d required %0d", cyc, LAT - 1);
        end
        drop_req(1'b1);
        wait_resp(1'b0, cyc);
        checks++;
        if (cyc !== LAT + 1 || i_rdata !== LINE_A5) begin
            failures++;
            $display("FAIL rstmid_i_after: cycles=%0d i_rdata=%h required %0d a5..", cyc, i_rdata, LAT + 1);
        end
        drop_req(1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        adapt_en = 1'b1;
        mon_en = 1'b0;
        resp_line = '0;
        test_reset();
        test_lone_i();
        test_lone_d_write();
        test_tie_after_reset();
        test_mid_service();
        test_repeat_tie();
        test_spurious_resp();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
